// File: rtl/corr_pkg.sv
// corr_pkg: shared definitions for the lag-scanning correlator.
//   state_e - scan FSM states
//   clog2   - ceiling log2, usable in parameter expressions
//   cw_of   - width of a match count for an n-bit frame (holds 0..n)
//   lw_of   - width of a lag index for m lags (at least 1 bit)
package corr_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cw_of(input int n);
    return clog2(n + 1);
  endfunction

  function automatic int lw_of(input int m);
    return (clog2(m) < 1) ? 1 : clog2(m);
  endfunction

endpackage

// File: rtl/corr_lag_scan_if.sv
// corr_lag_scan_if: control/data bundle of corr_lag_scan.
//   master drives Enable, P, DataIn1, DataIn2, Threshold
//   slave  drives Busy, Done, DataOut, PeakCount, PeakLag
//   (plus Inverted when CORR_ANTIPODAL_EN is defined)
interface corr_lag_scan_if
  import corr_pkg::*;
#(
  parameter int N       = 16,
  parameter int MAX_LAG = 4
);
  localparam int CW = cw_of(N);
  localparam int LW = lw_of(MAX_LAG);

  logic          Enable;
  logic          P;
  logic [N-1:0]  DataIn1;
  logic [N-1:0]  DataIn2;
  logic [CW-1:0] Threshold;
  logic          Busy;
  logic          Done;
  logic          DataOut;
  logic [CW-1:0] PeakCount;
  logic [LW-1:0] PeakLag;
`ifdef CORR_ANTIPODAL_EN
  logic          Inverted;
`endif

  modport master (
    output Enable, P, DataIn1, DataIn2, Threshold,
`ifdef CORR_ANTIPODAL_EN
    input  Inverted,
`endif
    input  Busy, Done, DataOut, PeakCount, PeakLag
  );

  modport slave (
    input  Enable, P, DataIn1, DataIn2, Threshold,
`ifdef CORR_ANTIPODAL_EN
    output Inverted,
`endif
    output Busy, Done, DataOut, PeakCount, PeakLag
  );

endinterface

// File: rtl/corr_popcount_lane.sv
// corr_popcount_lane: combinational XNOR match count over LANES bit pairs.
//   a_i, b_i : LANES-bit operands
//   cnt_o    : number of positions where a_i and b_i agree (0..LANES)
module corr_popcount_lane
  import corr_pkg::*;
#(
  parameter int LANES = 4,
  localparam int PW   = clog2(LANES + 1)
) (
  input  logic [LANES-1:0] a_i,
  input  logic [LANES-1:0] b_i,
  output logic [PW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < LANES; i++)
      cnt_o = cnt_o + PW'(~(a_i[i] ^ b_i[i]));
  end

endmodule

// File: rtl/corr_lag_scan.sv
// corr_lag_scan: captures two N-bit frames on P and scores their XNOR agreement
// at circular lags 0..MAX_LAG-1, LANES bits per clock, reporting the best score,
// its lag and a threshold decision.
//   Clk, Reset_n : clock, async active-low reset
//   bus (slave)  : Enable/P/DataIn1/DataIn2/Threshold in;
//                  Busy/Done/DataOut/PeakCount/PeakLag out
// Optional: CORR_ANTIPODAL_EN scores max(acc, N-acc) and adds bus.Inverted.
module corr_lag_scan
  import corr_pkg::*;
#(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  parameter int LANES   = 4,
  parameter int MAX_LAG = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  corr_lag_scan_if.slave bus
);

  localparam int N     = SAMPLES * OSF;
  localparam int CW    = cw_of(N);
  localparam int LW    = lw_of(MAX_LAG);
  localparam int BEATS = N / LANES;
  localparam int BW    = lw_of(BEATS);
  localparam int PW    = clog2(LANES + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  d1_q, d1_d, d2_q, d2_d;
  logic [CW-1:0] thr_q, thr_d, acc_q, acc_d, best_q, best_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] lag_q, lag_d, blag_q, blag_d;
  logic          busy_q, busy_d, done_q, done_d, dout_q, dout_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [LW-1:0] plag_q, plag_d;
  logic [PW-1:0] pc;
  logic [CW-1:0] score;

  corr_popcount_lane #(.LANES(LANES)) u_pc (
    .a_i  (d1_q[int'(beat_q)*LANES +: LANES]),
    .b_i  (d2_q[int'(beat_q)*LANES +: LANES]),
    .cnt_o(pc)
  );

`ifdef CORR_ANTIPODAL_EN
  logic          binv_q, binv_d, inv_q, inv_d, score_inv;
  logic [CW-1:0] anti;
  assign anti      = CW'(N) - acc_q;
  assign score_inv = anti > acc_q;
  assign score     = score_inv ? anti : acc_q;
  assign bus.Inverted = inv_q;
`else
  assign score = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    thr_d   = thr_q;
    beat_d  = beat_q;
    lag_d   = lag_q;
    acc_d   = acc_q;
    best_d  = best_q;
    blag_d  = blag_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    pcnt_d  = pcnt_q;
    plag_d  = plag_q;
`ifdef CORR_ANTIPODAL_EN
    binv_d  = binv_q;
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: if (bus.P) begin
        d1_d    = bus.DataIn1;
        d2_d    = bus.DataIn2;
        thr_d   = bus.Threshold;
        beat_d  = '0;
        lag_d   = '0;
        acc_d   = '0;
        best_d  = '0;
        blag_d  = '0;
`ifdef CORR_ANTIPODAL_EN
        binv_d  = 1'b0;
`endif
        busy_d  = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: begin
        acc_d = acc_q + CW'(pc);
        if (beat_q == BW'(BEATS - 1)) state_d = COMPARE;
        else                          beat_d  = beat_q + 1'b1;
      end
      COMPARE: begin
        // lag 0 always seeds the tracker; strict > keeps the lowest lag on ties
        if (score > best_q || lag_q == '0) begin
          best_d = score;
          blag_d = lag_q;
`ifdef CORR_ANTIPODAL_EN
          binv_d = score_inv;
`endif
        end
        // rotate right by one: next lag compares D1[i] with D2[(i+lag+1) mod N]
        d2_d    = (d2_q >> 1) | (d2_q << (N - 1));
        acc_d   = '0;
        beat_d  = '0;
        lag_d   = lag_q + 1'b1;
        state_d = (lag_q < LW'(MAX_LAG - 1)) ? ACCUM : DONE;
      end
      DONE: begin
        pcnt_d  = best_q;
        plag_d  = blag_q;
        dout_d  = best_q >= thr_q;
`ifdef CORR_ANTIPODAL_EN
        inv_d   = binv_q;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enable low freezes everything, which also stretches the Done pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      d1_q    <= '0;
      d2_q    <= '0;
      thr_q   <= '0;
      beat_q  <= '0;
      lag_q   <= '0;
      acc_q   <= '0;
      best_q  <= '0;
      blag_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
      pcnt_q  <= '0;
      plag_q  <= '0;
`ifdef CORR_ANTIPODAL_EN
      binv_q  <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else if (bus.Enable) begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      thr_q   <= thr_d;
      beat_q  <= beat_d;
      lag_q   <= lag_d;
      acc_q   <= acc_d;
      best_q  <= best_d;
      blag_q  <= blag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      pcnt_q  <= pcnt_d;
      plag_q  <= plag_d;
`ifdef CORR_ANTIPODAL_EN
      binv_q  <= binv_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DataOut   = dout_q;
  assign bus.PeakCount = pcnt_q;
  assign bus.PeakLag   = plag_q;

endmodule

// File: tb/tb_corr_lag_scan.sv
// tb_corr_lag_scan: table vectors, hand sequences (enable freeze, reset abort,
// ignored second P) and randomized frames checked against a lag-by-lag model.
module tb_corr_lag_scan;
  localparam int N = 16, MAX_LAG = 4, LAT = 21;

  logic Clk = 1'b0, Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  corr_lag_scan_if #(.N(N), .MAX_LAG(MAX_LAG)) bus_if();
  corr_lag_scan #(.SAMPLES(2), .OSF(8), .LANES(4), .MAX_LAG(MAX_LAG)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_if)
  );

  typedef struct {
    logic [N-1:0] d1, d2;
    logic [4:0]   thr;
    int           cnt, lag;
    bit           dout, inv;
  } vec_t;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: score every lag directly from the rotation definition.
  function automatic void model(input logic [N-1:0] d1, d2, input logic [4:0] thr,
                                output int cnt, output int lag, output bit dout, output bit inv);
    cnt = 0; lag = 0; inv = 0;
    for (int l = 0; l < MAX_LAG; l++) begin
      int m, sc;
      bit iv;
      m = 0;
      for (int i = 0; i < N; i++) if (d1[i] == d2[(i + l) % N]) m++;
      sc = m; iv = 0;
`ifdef CORR_ANTIPODAL_EN
      if (N - m > m) begin sc = N - m; iv = 1; end
`endif
      if (l == 0 || sc > cnt) begin cnt = sc; lag = l; inv = iv; end
    end
    dout = (cnt >= int'(thr));
  endfunction

  task automatic check_out(input string nm, input int cnt, input int lag, input bit dout, input bit inv);
    chk({nm, ".PeakCount"}, int'(bus_if.PeakCount), cnt);
    chk({nm, ".PeakLag"}, int'(bus_if.PeakLag), lag);
    chk({nm, ".DataOut"}, int'(bus_if.DataOut), int'(dout));
`ifdef CORR_ANTIPODAL_EN
    chk({nm, ".Inverted"}, int'(bus_if.Inverted), int'(inv));
`else
    if (inv) chk({nm, ".inv_unexpected"}, 1, 0);
`endif
  endtask

  // Pulse P, then wait (bounded) for Done; optional Enable gap and second P.
  task automatic run_scan(input logic [N-1:0] d1, d2, input logic [4:0] thr,
                          input int en_at, input int en_len, input int p2_at, output int lat);
    int cyc, extra;
    cyc = 0; extra = 0; lat = -1;
    @(negedge Clk);
    bus_if.DataIn1 = d1; bus_if.DataIn2 = d2; bus_if.Threshold = thr; bus_if.P = 1'b1;
    @(negedge Clk);
    bus_if.P = 1'b0;
    chk("busy_after_p", int'(bus_if.Busy), 1);
    while (lat < 0 && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      if (cyc == en_at) bus_if.Enable = 1'b0;
      if (cyc == en_at + en_len) bus_if.Enable = 1'b1;
      if (cyc == p2_at) begin bus_if.DataIn1 = '0; bus_if.P = 1'b1; end
      if (cyc == p2_at + 1) bus_if.P = 1'b0;
      if (bus_if.Done) lat = cyc;
    end
    if (lat >= 0) begin
      chk("busy_at_done", int'(bus_if.Busy), 0);
      repeat (4) begin
        @(negedge Clk);
        if (bus_if.Done) extra++;
      end
      chk("single_done", extra, 0);
    end
  endtask

  vec_t vt[5];
  int   lat, ecnt, elag, nd;
  bit   edout, einv;
  logic [N-1:0] rd1, rd2;
  logic [4:0]   rthr;

  initial begin
    bus_if.Enable = 1'b1; bus_if.P = 1'b0;
    bus_if.DataIn1 = '0; bus_if.DataIn2 = '0; bus_if.Threshold = '0;

    vt[0] = '{d1:16'hA221, d2:16'hA221, thr:5'd16, cnt:16, lag:0, dout:1, inv:0};
    vt[1] = '{d1:16'hC000, d2:16'h0003, thr:5'd12, cnt:16, lag:2, dout:1, inv:0};
`ifdef CORR_ANTIPODAL_EN
    vt[2] = '{d1:16'h0000, d2:16'hFFFF, thr:5'd1,  cnt:16, lag:0, dout:1, inv:1};
`else
    vt[2] = '{d1:16'h0000, d2:16'hFFFF, thr:5'd1,  cnt:0,  lag:0, dout:0, inv:0};
`endif
    vt[3] = '{d1:16'hFFFF, d2:16'hFFFF, thr:5'd17, cnt:16, lag:0, dout:0, inv:0};
    vt[4] = '{d1:16'h0001, d2:16'h0008, thr:5'd16, cnt:16, lag:3, dout:1, inv:0};

    // reset state
    repeat (3) @(negedge Clk);
    check_out("reset", 0, 0, 0, 0);
    chk("reset.Busy", int'(bus_if.Busy), 0);
    chk("reset.Done", int'(bus_if.Done), 0);
    Reset_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_scan(vt[k].d1, vt[k].d2, vt[k].thr, -1, 0, -1, lat);
      chk($sformatf("vec%0d.latency", k), lat, LAT);
      check_out($sformatf("vec%0d", k), vt[k].cnt, vt[k].lag, vt[k].dout, vt[k].inv);
    end

    // Enable low for 5 cycles during lag-1 accumulation
    run_scan(16'hA221, 16'hA221, 5'd16, 6, 5, -1, lat);
    chk("freeze.latency", lat, LAT + 5);
    check_out("freeze", 16, 0, 1, 0);

    // second P mid-scan is ignored
    run_scan(16'hA221, 16'hA221, 5'd16, -1, 0, 5, lat);
    chk("p2.latency", lat, LAT);
    check_out("p2", 16, 0, 1, 0);

    // reset during lag 2 aborts the scan and clears held results
    run_scan(16'hC000, 16'h0003, 5'd12, -1, 0, -1, lat);
    @(negedge Clk);
    bus_if.DataIn1 = 16'hA221; bus_if.DataIn2 = 16'hA221; bus_if.P = 1'b1;
    @(negedge Clk);
    bus_if.P = 1'b0;
    repeat (12) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check_out("rst_mid", 0, 0, 0, 0);
    chk("rst_mid.Busy", int'(bus_if.Busy), 0);
    chk("rst_mid.Done", int'(bus_if.Done), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge Clk);
      if (bus_if.Done) nd++;
    end
    chk("rst_mid.no_done", nd, 0);
    run_scan(16'hC000, 16'h0003, 5'd12, -1, 0, -1, lat);
    chk("after_rst.latency", lat, LAT);
    check_out("after_rst", 16, 2, 1, 0);

    // randomized frames vs model
    for (int r = 0; r < 25; r++) begin
      rd1  = N'($urandom);
      rthr = 5'($urandom_range(0, 17));
      case ($urandom_range(0, 2))
        0: rd2 = N'($urandom);
        1: begin
             int s;
             s = $urandom_range(0, N - 1);
             rd2 = (rd1 << s) | (rd1 >> (N - s));
             rd2 = rd2 ^ (N'(1) << $urandom_range(0, N - 1));
           end
        default: rd2 = ~rd1 ^ (N'($urandom) & N'($urandom) & N'($urandom));
      endcase
      model(rd1, rd2, rthr, ecnt, elag, edout, einv);
      run_scan(rd1, rd2, rthr, -1, 0, -1, lat);
      chk($sformatf("rand%0d.latency", r), lat, LAT);
      check_out($sformatf("rand%0d", r), ecnt, elag, edout, einv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
